// File: rtl/cache_pkg.sv
// Shared constants, address-field positions and FSM state type for the
// two-way set-associative read cache.
package cache_pkg;

  localparam int unsigned SETS      = 64;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned INDEX_W   = $clog2(SETS);
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned WORD_W    = 32;

  // Address slicing: [2] word select, [INDEX_LSB +: INDEX_W] set index, tag above.
  localparam int unsigned WORD_BIT  = 2;
  localparam int unsigned INDEX_LSB = 3;
  localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE_THRU
  } state_e;

  // Pick one 32-bit word out of a 64-bit line; word 0 is the low half.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic              sel);
    return sel ? line[WORD_W +: WORD_W] : line[0 +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_memory.sv
// Tag/data/valid/lru storage for the two-way cache. Lookup is combinational
// on the current index/tag; fills go to the victim way, write-hit updates
// and invalidations go to the hit way.
module cache_memory
  import cache_pkg::*;
#(
  parameter  int unsigned SETS  = cache_pkg::SETS,
  parameter  int unsigned TAG_W = cache_pkg::TAG_W,
  localparam int unsigned IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              hit0_o,
  output logic              hit1_o,
  output logic [LINE_W-1:0] hit_line_o,
  input  logic              fill_en_i,
  input  logic              touch_en_i,
  input  logic              upd_en_i,
  input  logic              inv_en_i,
  input  logic [LINE_W-1:0] line_i
);

  logic              valid0_q [SETS];
  logic              valid1_q [SETS];
  logic              lru_q    [SETS];
  logic [TAG_W-1:0]  tag0_q   [SETS];
  logic [TAG_W-1:0]  tag1_q   [SETS];
  logic [LINE_W-1:0] data0_q  [SETS];
  logic [LINE_W-1:0] data1_q  [SETS];

  logic hit0;
  logic hit1;
  logic hit_way;
  logic victim;

  // Lookup; way 0 wins if both ways ever match.
  assign hit0       = valid0_q[index_i] && (tag0_q[index_i] == tag_i);
  assign hit1       = valid1_q[index_i] && (tag1_q[index_i] == tag_i);
  assign hit_way    = ~hit0;
  assign hit0_o     = hit0;
  assign hit1_o     = hit1;
  assign hit_line_o = hit0 ? data0_q[index_i] : data1_q[index_i];

  // Victim: first invalid way, otherwise the way named by lru.
  assign victim = !valid0_q[index_i] ? 1'b0 :
                  !valid1_q[index_i] ? 1'b1 : lru_q[index_i];

  // Valid and lru state; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= '{default: 1'b0};
      valid1_q <= '{default: 1'b0};
      lru_q    <= '{default: 1'b0};
    end else if (fill_en_i) begin
      if (victim) valid1_q[index_i] <= 1'b1;
      else        valid0_q[index_i] <= 1'b1;
      lru_q[index_i] <= ~victim;
    end else if (touch_en_i || upd_en_i) begin
      lru_q[index_i] <= ~hit_way;
    end else if (inv_en_i) begin
      if (hit_way) valid1_q[index_i] <= 1'b0;
      else         valid0_q[index_i] <= 1'b0;
    end
  end

  // Tag and data arrays; not reset, only meaningful under a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      if (victim) begin
        tag1_q[index_i]  <= tag_i;
        data1_q[index_i] <= line_i;
      end else begin
        tag0_q[index_i]  <= tag_i;
        data0_q[index_i] <= line_i;
      end
    end else if (upd_en_i) begin
      if (hit_way) data1_q[index_i] <= line_i;
      else         data0_q[index_i] <= line_i;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative read cache between the MEM stage and the SRAM
// controller. Loads hit in zero cycles or fetch a line on a miss; stores
// are written through without allocation.
// Build option: CACHE_WRITE_UPDATE_EN -- when defined a write hit patches
// the cached word and refreshes lru; otherwise a write hit invalidates.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS  = cache_pkg::SETS,
  parameter int unsigned TAG_W = cache_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [31:0]       sram_address,
  output logic [31:0]       sram_wdata,
  output logic              sram_read,
  output logic              sram_write,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_LO = INDEX_LSB + IDX_W;

  state_e state_q;
  state_e state_d;

  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              word_sel;
  logic              hit0;
  logic              hit1;
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] line_wr;
  logic              fill_en;
  logic              touch_en;
  logic              wr_hit;
  logic              upd_en;
  logic              inv_en;

  assign index        = address[INDEX_LSB +: IDX_W];
  assign tag          = address[TAG_LO +: TAG_W];
  assign word_sel     = address[WORD_BIT];
  assign hit          = hit0 | hit1;
  assign sram_address = address;
  assign sram_wdata   = wdata;

`ifdef CACHE_WRITE_UPDATE_EN
  // Write hit rewrites the addressed word inside the hit line.
  always_comb begin
    line_wr = sram_rdata;
    if (!fill_en) begin
      line_wr = word_sel ? {wdata, hit_line[0 +: WORD_W]}
                         : {hit_line[WORD_W +: WORD_W], wdata};
    end
  end
  assign upd_en = wr_hit;
  assign inv_en = 1'b0;
`else
  assign line_wr = sram_rdata;
  assign upd_en  = 1'b0;
  assign inv_en  = wr_hit;
`endif

  cache_memory #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .index_i    (index),
    .tag_i      (tag),
    .hit0_o     (hit0),
    .hit1_o     (hit1),
    .hit_line_o (hit_line),
    .fill_en_i  (fill_en),
    .touch_en_i (touch_en),
    .upd_en_i   (upd_en),
    .inv_en_i   (inv_en),
    .line_i     (line_wr)
  );

  // State register; reset drops any outstanding SRAM request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, MEM-stage handshake, SRAM requests and array controls.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    rdata      = '0;
    sram_read  = 1'b0;
    sram_write = 1'b0;
    fill_en    = 1'b0;
    touch_en   = 1'b0;
    wr_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          state_d = WRITE_THRU;
        end else if (MEM_R_EN) begin
          if (hit) begin
            ready    = 1'b1;
            rdata    = line_word(hit_line, word_sel);
            touch_en = 1'b1;
          end else begin
            state_d = READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      READ_MISS: begin
        sram_read = 1'b1;
        if (sram_ready) begin
          fill_en = 1'b1;
          ready   = 1'b1;
          rdata   = line_word(sram_rdata, word_sel);
          state_d = IDLE;
        end
      end
      WRITE_THRU: begin
        sram_write = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          wr_hit  = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios followed by random traffic,
// checked against a per-set recency-list model of a 2-entry LRU cache.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: per set, up to two resident lines ordered most-recent first.
  int          m_cnt  [64];
  logic [9:0]  m_tag  [64][2];
  logic [63:0] m_line [64][2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [63:0] l, input logic b);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = l[31:0];
    hi = l[63:32];
    return b ? hi : lo;
  endfunction

  function automatic int m_find(input int s, input logic [9:0] t);
    for (int p = 0; p < m_cnt[s]; p++)
      if (m_tag[s][p] == t) return p;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  task automatic m_touch(input int s, input int p);
    logic [9:0]  t;
    logic [63:0] l;
    if (p == 1) begin
      t = m_tag[s][0];  l = m_line[s][0];
      m_tag[s][0] = m_tag[s][1];  m_line[s][0] = m_line[s][1];
      m_tag[s][1] = t;            m_line[s][1] = l;
    end
  endtask

  task automatic m_insert(input int s, input logic [9:0] t, input logic [63:0] l);
    m_tag[s][1]  = m_tag[s][0];
    m_line[s][1] = m_line[s][0];
    m_tag[s][0]  = t;
    m_line[s][0] = l;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic m_remove(input int s, input int p);
    if (p == 0) begin
      m_tag[s][0]  = m_tag[s][1];
      m_line[s][0] = m_line[s][1];
    end
    m_cnt[s]--;
  endtask

  // One load; the model decides hit or miss, the bench plays the SRAM.
  task automatic do_read(input logic [31:0] addr, input logic [63:0] line, input int lat);
    int         s;
    int         p;
    logic [9:0] t;
    s = int'(addr[8:3]);
    t = addr[18:9];
    p = m_find(s, t);
    @(negedge clk);
    address = addr; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    #1;
    if (p >= 0) begin
      chk("hit_ready", 64'(ready), 64'd1);
      chk("hit_rdata", 64'(rdata), 64'(wsel(m_line[s][p], addr[2])));
      chk("hit_no_sram_read", 64'(sram_read), 64'd0);
      m_touch(s, p);
      @(negedge clk);
      MEM_R_EN = 1'b0;
    end else begin
      chk("miss_ready_low", 64'(ready), 64'd0);
      chk("miss_rdata_zero", 64'(rdata), 64'd0);
      repeat (lat) begin
        @(negedge clk); #1;
        chk("miss_sram_read", 64'(sram_read), 64'd1);
        chk("miss_wait_ready", 64'(ready), 64'd0);
      end
      @(negedge clk);
      sram_rdata = line; sram_ready = 1'b1;
      #1;
      chk("fill_ready", 64'(ready), 64'd1);
      chk("fill_rdata", 64'(rdata), 64'(wsel(line, addr[2])));
      chk("fill_sram_read_held", 64'(sram_read), 64'd1);
      chk("fill_no_sram_write", 64'(sram_write), 64'd0);
      @(negedge clk);
      sram_ready = 1'b0; MEM_R_EN = 1'b0;
      #1;
      chk("fill_sram_read_drop", 64'(sram_read), 64'd0);
      chk("fill_idle_ready", 64'(ready), 64'd1);
      m_insert(s, t, line);
    end
  endtask

  // One store (optionally with MEM_R_EN also high); always write-through.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input logic both);
    int         s;
    int         p;
    logic [9:0] t;
    s = int'(addr[8:3]);
    t = addr[18:9];
    @(negedge clk);
    address = addr; wdata = data; MEM_W_EN = 1'b1; MEM_R_EN = both; sram_ready = 1'b0;
    #1;
    chk("wr_ready_low", 64'(ready), 64'd0);
    chk("wr_fwd_addr", 64'(sram_address), 64'(addr));
    chk("wr_fwd_data", 64'(sram_wdata), 64'(data));
    repeat (lat) begin
      @(negedge clk); #1;
      chk("wr_sram_write", 64'(sram_write), 64'd1);
      chk("wr_no_sram_read", 64'(sram_read), 64'd0);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    chk("wr_done_ready", 64'(ready), 64'd1);
    chk("wr_done_sram_write", 64'(sram_write), 64'd1);
    chk("wr_done_no_sram_read", 64'(sram_read), 64'd0);
    @(negedge clk);
    sram_ready = 1'b0; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    #1;
    chk("wr_sram_write_drop", 64'(sram_write), 64'd0);
    p = m_find(s, t);
    if (p >= 0) begin
`ifdef CACHE_WRITE_UPDATE_EN
      if (addr[2]) m_line[s][p][63:32] = data;
      else         m_line[s][p][31:0]  = data;
      m_touch(s, p);
`else
      m_remove(s, p);
`endif
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [63:0] l;
    int          op;

    rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    sram_rdata = '0; sram_ready = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_sram_read", 64'(sram_read), 64'd0);
    chk("rst_sram_write", 64'(sram_write), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then both words hit.
    do_read(32'h0000_0408, 64'h2222_2222_1111_1111, 2);
    do_read(32'h0000_040C, 64'h0, 0);
    do_read(32'h0000_0408, 64'h0, 0);

    // Eviction on index 1: tags 2 (A), 3 (B), 4 (C).
    do_read(32'h0000_0608, 64'hBBBB_BBB1_BBBB_BBB0, 1);
    do_read(32'h0000_0408, 64'h0, 0);
    do_read(32'h0000_0808, 64'hCCCC_CCC1_CCCC_CCC0, 3);
    do_read(32'h0000_0408, 64'h0, 0);
    do_read(32'h0000_060C, 64'hBBBB_BBB3_BBBB_BBB2, 0);

    // Write hit, then read back.
    do_write(32'h0000_0408, 32'hDEAD_BEEF, 2, 1'b0);
    do_read(32'h0000_0408, 64'h4444_4444_3333_3333, 1);

    // Simultaneous read and write enables take the write path.
    do_write(32'h0000_0608, 32'h1234_5678, 1, 1'b1);

    // Stray sram_ready while idle changes nothing.
    @(negedge clk);
    sram_ready = 1'b1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("idle_stray_ready", 64'(ready), 64'd1);
    chk("idle_stray_no_read", 64'(sram_read), 64'd0);
    chk("idle_stray_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    sram_ready = 1'b0;
    do_read(32'h0000_0808, 64'h5555_5555_6666_6666, 1);

    // Reset in the middle of a miss.
    @(negedge clk);
    address = 32'h0000_1010; MEM_R_EN = 1'b1;
    @(negedge clk); #1;
    chk("mid_miss_sram_read", 64'(sram_read), 64'd1);
    @(negedge clk);
    rst = 1'b1; MEM_R_EN = 1'b0;
    #1;
    chk("mid_rst_sram_read", 64'(sram_read), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0000_1010, 64'h7777_7777_8888_8888, 1);
    do_read(32'h0000_0408, 64'h9999_9999_AAAA_AAAA, 0);

    // Random traffic over a few sets and tags to force hits and evictions.
    for (int i = 0; i < 300; i++) begin
      a  = {13'($urandom), 10'($urandom_range(0, 3)), 6'($urandom_range(0, 2)),
            1'($urandom), 2'($urandom)};
      l  = {$urandom, $urandom};
      op = $urandom_range(0, 9);
      if (op < 7)       do_read(a, l, $urandom_range(0, 3));
      else if (op < 9)  do_write(a, $urandom, $urandom_range(0, 3), 1'b0);
      else              do_write(a, $urandom, $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
